ecc_secded_decoder_pipe: RTL and testbench
==========================================

Name: ecc_secded_decoder_pipe

Overview:
- Pipelined, parametrised Hamming SECDED decoder with valid/ready handshake on both sides.
- Corrects single-bit errors and flags double-bit errors.
- Reports syndrome and error position per word; keeps saturating corrected/uncorrectable error counters.
- Sits between memory read data and the consumer. Uses the same codeword layout as ecc_encoder, so encoder output feeds it directly.

Parameters:
- data_bit_width, 64, data bits per word.
- redundant_bit_width, 8, check bits (1 overall parity + Hamming bits). Must satisfy 2^(redundant_bit_width-1) >= data_bit_width+redundant_bit_width.
- cnt_width, 16, width of each error counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- dec_data_in  in  N=data_bit_width+redundant_bit_width  codeword
- dec_valid_in  in  1  codeword valid
- dec_ready_out  out  1  decoder can accept
- corr_en  in  1  1 = correct single errors; 0 = pass data raw, flags still reported
- dec_data_out  out  data_bit_width  decoded data
- dec_valid_out  out  1  output valid
- dec_ready_in  in  1  consumer accepts
- ce_out  out  1  single error detected (corrected if corr_en)
- ue_out  out  1  uncorrectable error
- syndrome_out  out  redundant_bit_width-1  Hamming syndrome
- err_pos_out  out  $clog2(N)  codeword index of corrected bit; 0 when no ce
- cnt_clr  in  1  synchronous clear of both counters
- ce_count  out  cnt_width  saturating count of ce words
- ue_count  out  cnt_width  saturating count of ue words

Behaviour:
- Codeword layout: index 0 = overall parity. Index 2^k (k=0..redundant_bit_width-2) = Hamming bit k+1. Remaining indices, ascending = data bits, LSB first.
- Stage 1 registers the codeword and corr_en, plus:
  - syndrome s = XOR of indices i (1..N-1) whose bit is 1;
  - P = XOR of all N bits.
- Stage 2 classifies and registers outputs:
  - s=0, P=0: clean; ce=0, ue=0.
  - P=1, s<N: ce=1; err_pos=s; bit s flipped before data extraction if corr_en. s=0 means the parity bit itself; data unchanged.
  - P=1, s>=N: ue=1 (shortened-code alias).
  - P=0, s!=0: ue=1; data output raw.
- Latency: 2 cycles from input handshake to dec_valid_out when unstalled. Throughput 1 word/cycle.
- Handshake:
  - s2_adv = !dec_valid_out || dec_ready_in
  - s1_adv = !s1_valid || s2_adv
  - dec_ready_out = s1_adv
- Input is accepted when dec_valid_in && dec_ready_out.
- All output fields hold stable while dec_valid_out && !dec_ready_in.
- corr_en is sampled with the word; mid-stream changes affect only later words.
- Counters update on the output handshake only (dec_valid_out && dec_ready_in). Each word is counted once.
- Counters saturate at 2^cnt_width-1; no wrap.
- cnt_clr has priority: counters go to 0 and a coincident count event is dropped.
- Reset: dec_valid_out=0, stage-1 valid=0, ce_out=0, ue_out=0, syndrome_out=0, err_pos_out=0, dec_data_out=0, counters=0, dec_ready_out=1 the cycle after rst deasserts.
- rst mid-operation: all in-flight words are discarded and not counted.

Test Plan:
- Encode 64'h0123_4567_89AB_CDEF, no flip, corr_en=1 -> 2 cycles later data=64'h0123_4567_89AB_CDEF, ce=0, ue=0, syndrome=0.
- Same word, flip index 3 -> data restored, ce=1, syndrome=3, err_pos=3, ce_count=1. Repeat with corr_en=0 -> data bit 0 inverted, ce=1.
- Flip index 0 -> ce=1, syndrome=0, err_pos=0, data correct. Flip indices 5 and 9 -> ue=1, ce=0, syndrome=12, ue_count increments.
- Sweep every index 0..71 with a random word per flip -> all corrected, ce_count=72; a double flip per index pair (i, i+1) -> all ue.
- Stream 10 words with dec_ready_in low on cycles 3-6 -> no loss or duplication, outputs stable while stalled, dec_ready_out drops once both stages are full.
- cnt_width=4: 20 single-error words -> ce_count=15. cnt_clr asserted on a ce handshake -> ce_count=0. rst with 2 words in flight -> dec_valid_out=0, counters=0.

Source files
------------

// File: rtl/ecc_secded_decoder_pipe.sv
// ecc_secded_decoder_pipe
//
// Two-stage pipelined Hamming SECDED decoder. Stage 1 registers the codeword
// with its syndrome and overall parity; stage 2 classifies the word, optionally
// corrects a single flipped bit, extracts the data bits and registers all
// output fields. Saturating counters track corrected (ce) and uncorrectable
// (ue) words as they leave the decoder.
//
// Codeword layout (N = data_bit_width + redundant_bit_width):
//   index 0        overall parity over all N bits
//   index 2^k      Hamming check bit k+1 (k = 0 .. redundant_bit_width-2)
//   other indices  data bits, ascending, LSB first
//
// Handshake (both sides): a word moves across an interface on a rising edge
// where valid and ready are both high. valid must not depend on ready; once a
// stage holds a valid word it keeps it, unchanged, until it is taken.
//   s2_adv        = !dec_valid_out || dec_ready_in
//   s1_adv        = !s1_valid || s2_adv
//   dec_ready_out = s1_adv
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   dec_data_in     codeword in
//   dec_valid_in    codeword valid
//   dec_ready_out   decoder can accept a codeword this cycle
//   corr_en         1 = correct single errors, 0 = pass data raw (sampled with the word)
//   dec_data_out    decoded data
//   dec_valid_out   output valid
//   dec_ready_in    consumer accepts
//   ce_out          single error detected (corrected if corr_en was set)
//   ue_out          uncorrectable error
//   syndrome_out    Hamming syndrome of the word
//   err_pos_out     codeword index of the single error, 0 when ce_out is low
//   cnt_clr         synchronous clear of both counters, wins over a count event
//   ce_count        saturating count of ce words handed to the consumer
//   ue_count        saturating count of ue words handed to the consumer

module ecc_secded_decoder_pipe #(
    parameter int data_bit_width      = 64,
    parameter int redundant_bit_width = 8,
    parameter int cnt_width           = 16,
    localparam int N  = data_bit_width + redundant_bit_width,
    localparam int SW = redundant_bit_width - 1,
    localparam int PW = $clog2(N)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N-1:0]              dec_data_in,
    input  logic                      dec_valid_in,
    output logic                      dec_ready_out,
    input  logic                      corr_en,
    output logic [data_bit_width-1:0] dec_data_out,
    output logic                      dec_valid_out,
    input  logic                      dec_ready_in,
    output logic                      ce_out,
    output logic                      ue_out,
    output logic [SW-1:0]             syndrome_out,
    output logic [PW-1:0]             err_pos_out,
    input  logic                      cnt_clr,
    output logic [cnt_width-1:0]      ce_count,
    output logic [cnt_width-1:0]      ue_count
);

    // Syndromes at or above N name a bit that does not exist in the
    // shortened code; one extra bit keeps the compare exact when N = 2^SW.
    localparam logic [SW:0] n_lim = (SW+1)'(N);

    // Codeword index holding data bit j: the j-th non-power-of-two index >= 1.
    function automatic int data_idx(input int j);
        int c;
        int r;
        c = 0;
        r = 0;
        for (int i = 1; i < N; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (c == j) r = i;
                c++;
            end
        end
        return r;
    endfunction

    // ---------------- handshake ----------------
    logic s1_valid;
    logic s1_adv;
    logic s2_adv;
    logic out_hs;

    assign s2_adv        = !dec_valid_out || dec_ready_in;
    assign s1_adv        = !s1_valid || s2_adv;
    assign dec_ready_out = s1_adv;
    assign out_hs        = dec_valid_out && dec_ready_in;

    // ---------------- stage 1 ----------------
    logic [SW-1:0] syn_c;
    logic          par_c;

    always_comb begin
        syn_c = '0;
        for (int i = 1; i < N; i++) begin
            if (dec_data_in[i]) syn_c = syn_c ^ SW'(i);
        end
        par_c = ^dec_data_in;
    end

    logic [N-1:0]  s1_code;
    logic          s1_corr;
    logic [SW-1:0] s1_syn;
    logic          s1_par;

    // ---------------- stage 2 combinational ----------------
    logic                      ce_c;
    logic                      ue_c;
    logic [N-1:0]              fix_c;
    logic [data_bit_width-1:0] data_c;
    logic [PW-1:0]             pos_c;

    always_comb begin
        ce_c  = s1_par && ({1'b0, s1_syn} < n_lim);
        ue_c  = (s1_par && !ce_c) || (!s1_par && (s1_syn != '0));
        pos_c = ce_c ? s1_syn[PW-1:0] : '0;
        fix_c = s1_code;
        // Syndrome 0 with odd parity flips the overall parity bit, which is
        // not part of the extracted data, so the data is unaffected.
        if (ce_c && s1_corr) fix_c[pos_c] = ~s1_code[pos_c];
    end

    for (genvar j = 0; j < data_bit_width; j++) begin : g_extract
        assign data_c[j] = fix_c[data_idx(j)];
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_code       <= '0;
            s1_corr       <= 1'b0;
            s1_syn        <= '0;
            s1_par        <= 1'b0;
            dec_valid_out <= 1'b0;
            dec_data_out  <= '0;
            ce_out        <= 1'b0;
            ue_out        <= 1'b0;
            syndrome_out  <= '0;
            err_pos_out   <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= dec_valid_in;
                if (dec_valid_in) begin
                    s1_code <= dec_data_in;
                    s1_corr <= corr_en;
                    s1_syn  <= syn_c;
                    s1_par  <= par_c;
                end
            end
            if (s2_adv) begin
                dec_valid_out <= s1_valid;
                if (s1_valid) begin
                    dec_data_out <= data_c;
                    ce_out       <= ce_c;
                    ue_out       <= ue_c;
                    syndrome_out <= s1_syn;
                    err_pos_out  <= pos_c;
                end
            end
        end
    end

    // Counters advance only when a word is handed to the consumer, so a
    // stalled word is counted exactly once.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            ce_count <= '0;
            ue_count <= '0;
        end else if (out_hs) begin
            if (ce_out && (ce_count != '1)) ce_count <= ce_count + 1'b1;
            if (ue_out && (ue_count != '1)) ue_count <= ue_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_ecc_secded_decoder_pipe.sv
module tb_ecc_secded_decoder_pipe;

    localparam int D  = 64;
    localparam int R  = 8;
    localparam int N  = D + R;
    localparam int SW = R - 1;
    localparam int PW = $clog2(N);
    localparam logic [D-1:0] W0 = 64'h0123_4567_89AB_CDEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0] dec_data_in  = '0;
    logic         dec_valid_in = 1'b0;
    logic         corr_en      = 1'b1;
    logic         dec_ready_in = 1'b1;
    logic         cnt_clr      = 1'b0;

    logic          dec_ready_out, dec_valid_out, ce_out, ue_out;
    logic [D-1:0]  dec_data_out;
    logic [SW-1:0] syndrome_out;
    logic [PW-1:0] err_pos_out;
    logic [15:0]   ce_count, ue_count;

    logic          ready_4, valid_4, ce_4, ue_4;
    logic [D-1:0]  data_4;
    logic [SW-1:0] syn_4;
    logic [PW-1:0] pos_4;
    logic [3:0]    ce_count_4, ue_count_4;

    ecc_secded_decoder_pipe #(.data_bit_width(D), .redundant_bit_width(R), .cnt_width(16)) dut (
        .clk(clk), .rst(rst), .dec_data_in(dec_data_in), .dec_valid_in(dec_valid_in),
        .dec_ready_out(dec_ready_out), .corr_en(corr_en), .dec_data_out(dec_data_out),
        .dec_valid_out(dec_valid_out), .dec_ready_in(dec_ready_in), .ce_out(ce_out),
        .ue_out(ue_out), .syndrome_out(syndrome_out), .err_pos_out(err_pos_out),
        .cnt_clr(cnt_clr), .ce_count(ce_count), .ue_count(ue_count)
    );

    ecc_secded_decoder_pipe #(.data_bit_width(D), .redundant_bit_width(R), .cnt_width(4)) dut4 (
        .clk(clk), .rst(rst), .dec_data_in(dec_data_in), .dec_valid_in(dec_valid_in),
        .dec_ready_out(ready_4), .corr_en(corr_en), .dec_data_out(data_4),
        .dec_valid_out(valid_4), .dec_ready_in(dec_ready_in), .ce_out(ce_4),
        .ue_out(ue_4), .syndrome_out(syn_4), .err_pos_out(pos_4),
        .cnt_clr(cnt_clr), .ce_count(ce_count_4), .ue_count(ue_count_4)
    );

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [D-1:0]  data;
        logic          ce;
        logic          ue;
        logic [SW-1:0] syn;
        logic [PW-1:0] pos;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur_exp;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   m_ce   = 0;
    int   m_ue   = 0;
    int   n_out  = 0;
    logic ready_low = 1'b0;

    logic [D-1:0]  last_data;
    logic          last_ce, last_ue;
    logic [SW-1:0] last_syn;
    logic [PW-1:0] last_pos;

    logic          hold_pending = 1'b0;
    logic [D-1:0]  hold_data;
    logic          hold_ce, hold_ue;
    logic [SW-1:0] hold_syn;
    logic [PW-1:0] hold_pos;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic logic [63:0] sat(input int v, input int w);
        int lim;
        lim = (1 << w) - 1;
        return (v > lim) ? 64'(lim) : 64'(v);
    endfunction

    // ---------------- behavioural model ----------------
    function automatic logic [N-1:0] enc(input logic [D-1:0] d);
        logic [N-1:0] cw;
        logic         p;
        int           j;
        cw = '0;
        j  = 0;
        for (int i = 1; i < N; i++) begin
            if ((i & (i - 1)) != 0) begin
                cw[i] = d[j];
                j++;
            end
        end
        for (int k = 0; k < R - 1; k++) begin
            p = 1'b0;
            for (int i = 1; i < N; i++)
                if ((((i >> k) & 1) == 1) && ((i & (i - 1)) != 0)) p = p ^ cw[i];
            cw[1 << k] = p;
        end
        cw[0] = ^cw;
        return cw;
    endfunction

    function automatic logic [D-1:0] extract(input logic [N-1:0] cw);
        logic [D-1:0] d;
        int           j;
        d = '0;
        j = 0;
        for (int i = 1; i < N; i++) begin
            if ((i & (i - 1)) != 0) begin
                d[j] = cw[i];
                j++;
            end
        end
        return d;
    endfunction

    // The expected outcome follows from which bits were flipped: one flip is
    // a located single error, two flips are uncorrectable, and an odd flip
    // count whose index XOR lands outside the codeword is an alias.
    task automatic send(input logic [D-1:0] d, input int nf, input int f0, input int f1,
                        input int f2, input logic corr);
        logic [N-1:0] cw;
        int           s;
        exp_t         e;
        logic         ok;
        int           fl[3];
        fl[0] = f0; fl[1] = f1; fl[2] = f2;
        cw = enc(d);
        s  = 0;
        for (int k = 0; k < nf; k++) begin
            cw[fl[k]] = ~cw[fl[k]];
            s = s ^ fl[k];
        end
        e.ce   = (nf % 2 == 1) && (s < N);
        e.ue   = ((nf % 2 == 1) && (s >= N)) || ((nf % 2 == 0) && (nf > 0));
        e.syn  = SW'(s);
        e.pos  = e.ce ? PW'(s) : '0;
        e.data = (e.ce && corr) ? d : extract(cw);
        cur_exp      = e;
        dec_data_in  = cw;
        corr_en      = corr;
        dec_valid_in = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (dec_ready_out) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("input_accept");
        @(posedge clk);
        #1;
        dec_valid_in = 1'b0;
    endtask

    task automatic drain();
        logic ok;
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !dec_valid_out) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("drain");
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_ce = 0;
            m_ue = 0;
            hold_pending = 1'b0;
        end else begin
            exp_t e;
            logic hs_out;
            chk("ce_count", ce_count, sat(m_ce, 16));
            chk("ue_count", ue_count, sat(m_ue, 16));
            chk("ce_count_4", ce_count_4, sat(m_ce, 4));
            chk("ue_count_4", ue_count_4, sat(m_ue, 4));
            if (!dec_ready_out) ready_low = 1'b1;
            if (hold_pending && dec_valid_out) begin
                chk("hold_data", dec_data_out, hold_data);
                chk("hold_ce", ce_out, hold_ce);
                chk("hold_ue", ue_out, hold_ue);
                chk("hold_syn", syndrome_out, hold_syn);
                chk("hold_pos", err_pos_out, hold_pos);
            end
            hold_pending = dec_valid_out && !dec_ready_in;
            hold_data = dec_data_out; hold_ce = ce_out; hold_ue = ue_out;
            hold_syn = syndrome_out; hold_pos = err_pos_out;
            hs_out = dec_valid_out && dec_ready_in;
            e.ce = 1'b0;
            e.ue = 1'b0;
            if (hs_out) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    e = exp_q.pop_front();
                    n_out++;
                    chk("data", dec_data_out, e.data);
                    chk("ce", ce_out, e.ce);
                    chk("ue", ue_out, e.ue);
                    chk("syndrome", syndrome_out, e.syn);
                    chk("err_pos", err_pos_out, e.pos);
                    chk("data_4", data_4, e.data);
                    chk("ce_4", ce_4, e.ce);
                    chk("ue_4", ue_4, e.ue);
                    chk("valid_4", valid_4, 1'b1);
                    chk("syn_4", syn_4, e.syn);
                    chk("pos_4", pos_4, e.pos);
                    last_data = dec_data_out; last_ce = ce_out; last_ue = ue_out;
                    last_syn = syndrome_out; last_pos = err_pos_out;
                end
            end
            if (dec_valid_in && dec_ready_out) exp_q.push_back(cur_exp);
            if (cnt_clr) begin
                m_ce = 0;
                m_ue = 0;
            end else if (hs_out) begin
                m_ce = m_ce + (e.ce ? 1 : 0);
                m_ue = m_ue + (e.ue ? 1 : 0);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", dec_valid_out, 1'b0);
        chk("rst_ready", dec_ready_out, 1'b1);
        chk("rst_ce", ce_out, 1'b0);
        chk("rst_ue", ue_out, 1'b0);
        chk("rst_syn", syndrome_out, 0);
        chk("rst_pos", err_pos_out, 0);
        chk("rst_data", dec_data_out, 0);
        @(posedge clk);
        #1;

        // Clean word with latency check.
        send(W0, 0, 0, 0, 0, 1'b1);
        @(negedge clk);
        chk("lat_early", dec_valid_out, 1'b0);
        @(negedge clk);
        chk("lat_2", dec_valid_out, 1'b1);
        @(posedge clk);
        #1;
        drain();
        chk("t1_data", last_data, W0);
        chk("t1_ce", last_ce, 1'b0);
        chk("t1_ue", last_ue, 1'b0);
        chk("t1_syn", last_syn, 0);

        send(W0, 1, 3, 0, 0, 1'b1);
        drain();
        chk("t2_data", last_data, W0);
        chk("t2_ce", last_ce, 1'b1);
        chk("t2_syn", last_syn, 3);
        chk("t2_pos", last_pos, 3);
        chk("t2_ce_count", ce_count, 1);

        send(W0, 1, 3, 0, 0, 1'b0);
        drain();
        chk("t3_data_raw", last_data, W0 ^ 64'h1);
        chk("t3_ce", last_ce, 1'b1);

        send(W0, 1, 0, 0, 0, 1'b1);
        drain();
        chk("t4_ce", last_ce, 1'b1);
        chk("t4_syn", last_syn, 0);
        chk("t4_pos", last_pos, 0);
        chk("t4_data", last_data, W0);

        send(W0, 2, 5, 9, 0, 1'b1);
        drain();
        chk("t5_ue", last_ue, 1'b1);
        chk("t5_ce", last_ce, 1'b0);
        chk("t5_syn", last_syn, 12);
        chk("t5_ue_count", ue_count, 1);

        // Odd flips aliasing beyond the codeword length.
        send(W0, 3, 64, 8, 1, 1'b1);
        drain();
        chk("t6_ue", last_ue, 1'b1);
        chk("t6_ce", last_ce, 1'b0);
        chk("t6_syn", last_syn, 73);

        // Single-flip sweep over every index.
        clr();
        for (int i = 0; i < N; i++)
            send({$urandom, $urandom}, 1, i, 0, 0, 1'b1);
        drain();
        chk("sweep_ce_count", ce_count, 72);
        chk("sweep_ue_count", ue_count, 0);
        chk("sweep_ce_count_4", ce_count_4, 15);

        clr();
        for (int i = 0; i < N - 1; i++)
            send({$urandom, $urandom}, 2, i, i + 1, 0, 1'b1);
        drain();
        chk("dbl_ue_count", ue_count, 71);
        chk("dbl_ce_count", ce_count, 0);

        // Stream with a consumer stall.
        ready_low = 1'b0;
        n_out = 0;
        fork
            begin
                for (int w = 0; w < 10; w++)
                    send({$urandom, $urandom}, w % 3, w, w + 20, 0, 1'b1);
            end
            begin
                for (int c = 0; c < 9; c++) begin
                    dec_ready_in = !(c >= 3 && c <= 6);
                    @(posedge clk);
                    #1;
                end
                dec_ready_in = 1'b1;
            end
        join
        drain();
        chk("stream_count", n_out, 10);
        chk("stream_ready_low", ready_low, 1'b1);

        // Narrow counter saturation.
        clr();
        for (int w = 0; w < 20; w++)
            send({$urandom, $urandom}, 1, $urandom_range(0, N - 1), 0, 0, 1'b1);
        drain();
        chk("sat_ce_count_4", ce_count_4, 15);
        chk("sat_ce_count", ce_count, 20);

        // Clear coincident with a ce handshake.
        dec_ready_in = 1'b0;
        send(W0, 1, 7, 0, 0, 1'b1);
        begin
            logic ok;
            ok = 1'b0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (dec_valid_out) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) fail_now("clr_wait");
        end
        @(posedge clk);
        #1;
        dec_ready_in = 1'b1;
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        @(negedge clk);
        chk("clr_ce_count", ce_count, 0);
        chk("clr_ce_count_4", ce_count_4, 0);
        @(posedge clk);
        #1;

        // Reset with two words in flight.
        send(W0, 1, 0, 0, 0, 1'b1);
        drain();
        dec_ready_in = 1'b0;
        send(W0, 1, 4, 0, 0, 1'b1);
        send(W0, 2, 4, 6, 0, 1'b1);
        @(negedge clk);
        chk("flight_full", dec_ready_out, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        dec_ready_in = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", dec_valid_out, 1'b0);
        chk("mid_rst_ce_count", ce_count, 0);
        chk("mid_rst_ue_count", ue_count, 0);
        chk("mid_rst_ready_4", ready_4, 1'b1);
        repeat (4) @(negedge clk);
        chk("mid_rst_no_output", dec_valid_out, 1'b0);
        chk("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
